// File: rtl/capture_readout_sched.sv
// capture_readout_sched: frame sequencer gating DATA_NUM ADC strobes into the sample FIFO (out_fifo_wrreq), settling, then draining it bytewise to the UART (out_fifo_rdreq/in_fifo_q -> out_tx_data/out_tx_start, in_tx_busy handshake); in_start/in_continuous control, out_busy/out_done/out_err status, in_rst async active-low; define FRAME_HEADER_EN to prefix each frame with sync bytes A5 5A
module capture_readout_sched #(
  parameter int DATA_NUM = 405,
  parameter int SETTLE_CYC = 8,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_start,
  input  logic       in_continuous,
  input  logic       in_sample_en,
  output logic       out_fifo_wrreq,
  output logic       out_fifo_rdreq,
  input  logic       in_fifo_empty,
  input  logic [7:0] in_fifo_q,
  output logic [7:0] out_tx_data,
  output logic       out_tx_start,
  input  logic       in_tx_busy,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
);
  typedef enum logic [2:0] {IDLE, CAPTURE, SETTLE, READ, WAIT_Q, SEND, WAIT_TX, HOLDOFF} state_t;
  localparam logic [9:0] LAST_IDX = 10'(DATA_NUM - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYC - 1);
`ifdef FRAME_HEADER_EN
  localparam bit HDR_ON = 1'b1;
  logic [1:0] hdr;
`else
  localparam bit HDR_ON = 1'b0;
  localparam logic [1:0] hdr = 2'd0;
`endif
  state_t state, state_n;
  logic [9:0] wr_cnt, rd_cnt;
  logic [15:0] tmr;
  logic [7:0] hold;
  logic tmr_hit, tx_done, send_go, enter_cap;
  assign out_fifo_wrreq = state == CAPTURE && in_sample_en;
  assign out_fifo_rdreq = state == READ && !in_fifo_empty;
  assign out_busy = state != IDLE;
  assign tmr_hit = tmr == (state == SETTLE ? SETTLE_LAST : HOLD_LAST);
  assign send_go = state == SEND && !in_tx_busy;
  assign tx_done = state == WAIT_TX && !out_tx_start && !in_tx_busy;
  assign enter_cap = state_n == CAPTURE && state != CAPTURE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_start ? CAPTURE : IDLE;
      CAPTURE: state_n = out_fifo_wrreq && wr_cnt == LAST_IDX ? SETTLE : CAPTURE;
      SETTLE:  state_n = !tmr_hit ? SETTLE : HDR_ON ? SEND : READ;
      READ:    state_n = in_fifo_empty ? HOLDOFF : WAIT_Q;
      WAIT_Q:  state_n = SEND;
      SEND:    state_n = send_go ? WAIT_TX : SEND;
      WAIT_TX: state_n = !tx_done ? WAIT_TX : hdr == 2'd1 ? SEND : hdr == 2'd2 ? READ :
                         rd_cnt == LAST_IDX ? HOLDOFF : READ;
      HOLDOFF: state_n = !tmr_hit ? HOLDOFF : in_continuous ? CAPTURE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      tmr <= '0;
      hold <= '0;
      out_tx_data <= '0;
      out_tx_start <= 1'b0;
      out_done <= 1'b0;
      out_err <= 1'b0;
`ifdef FRAME_HEADER_EN
      hdr <= 2'd0;
`endif
    end else begin
      state <= state_n;
      tmr <= (state == SETTLE || state == HOLDOFF) && !tmr_hit ? tmr + 16'd1 : 16'd0;
      wr_cnt <= enter_cap ? 10'd0 : wr_cnt + 10'(out_fifo_wrreq);
      rd_cnt <= enter_cap ? 10'd0 : rd_cnt + 10'(tx_done && hdr == 2'd0);
      out_tx_start <= send_go;
      out_done <= tx_done && hdr == 2'd0 && rd_cnt == LAST_IDX;
      if (send_go)
        out_tx_data <= hold;
      if (state == IDLE && in_start)
        out_err <= 1'b0;
      else if (state == READ && in_fifo_empty)
        out_err <= 1'b1;
`ifdef FRAME_HEADER_EN
      hold <= state == WAIT_Q ? in_fifo_q : state == SETTLE && tmr_hit ? 8'hA5 :
              tx_done && hdr == 2'd1 ? 8'h5A : hold;
      if (state == SETTLE && tmr_hit)
        hdr <= 2'd1;
      else if (tx_done && hdr != 2'd0)
        hdr <= hdr == 2'd1 ? 2'd2 : 2'd0;
`else
      if (state == WAIT_Q)
        hold <= in_fifo_q;
`endif
    end
  end
endmodule

// File: tb/tb_capture_readout_sched.sv
// tb_capture_readout_sched: directed/random frames against a FIFO+UART model and a list-based expected byte stream
module tb_capture_readout_sched;
  localparam int DN = 4;
`ifdef FRAME_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, cont = 1'b0, sen = 1'b0, fe = 1'b1;
  logic busy_in, wrreq, rdreq, tx_start, busy, done, err;
  logic [7:0] fq = 8'h00, txd, adc_data = 8'h00;
  int checks = 0, errors = 0;
  int nwr = 0, nrd = 0, ndone = 0, nstart = 0, lim = -1, bcnt = 0;
  bit flush = 1'b0, stall = 1'b0;
  logic [7:0] fifo[$], rx[$], smp[$], exp_q[$];
  always #5 clk = ~clk;
  capture_readout_sched #(.DATA_NUM(DN), .SETTLE_CYC(2), .HOLDOFF_CYC(3)) dut (
    .in_clk(clk), .in_rst(rst_n), .in_start(start), .in_continuous(cont),
    .in_sample_en(sen), .out_fifo_wrreq(wrreq), .out_fifo_rdreq(rdreq),
    .in_fifo_empty(fe), .in_fifo_q(fq), .out_tx_data(txd), .out_tx_start(tx_start),
    .in_tx_busy(busy_in), .out_busy(busy), .out_done(done), .out_err(err)
  );
  assign busy_in = stall || bcnt != 0;
  always @(posedge clk) begin
    if (flush)
      fifo.delete();
    else begin
      if (wrreq) fifo.push_back(adc_data);
      if (rdreq && fifo.size() > 0) fq <= fifo.pop_front();
    end
    fe <= fifo.size() == 0 || (lim >= 0 && nrd + int'(rdreq) >= lim);
    nwr <= nwr + int'(wrreq);
    nrd <= nrd + int'(rdreq);
    ndone <= ndone + int'(done);
    nstart <= nstart + int'(tx_start);
    if (tx_start) begin
      rx.push_back(txd);
      bcnt <= 5;
    end else if (bcnt != 0)
      bcnt <= bcnt - 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic strobe(input logic [7:0] d, input int gap);
    adc_data = d;
    sen = 1'b1;
    smp.push_back(d);
    tick;
    sen = 1'b0;
    repeat (gap) tick;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic add_hdr;
`ifdef FRAME_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`endif
  endtask
  task automatic add_frame;
    add_hdr;
    for (int i = 0; i < DN; i++) exp_q.push_back(smp[i]);
    smp.delete();
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 400) begin
      tick;
      k++;
    end
    check(tag, done, 1'b1);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 400) begin
      tick;
      k++;
    end
    check(tag, busy, 1'b0);
  endtask
  task automatic compare_rx(input string tag, input int base);
    check({tag, "_len"}, rx.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < rx.size()) check({tag, "_byte"}, rx[base + i], exp_q[i]);
    exp_q.delete();
  endtask
  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
  endtask
  initial begin
    int b_rx, b_wr, b_dn, b_st, b_rd, k;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wrreq", wrreq, 1'b0);
    check("rst_rdreq", rdreq, 1'b0);
    check("rst_start", tx_start, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_txd", txd, 8'h00);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    // basic frame: six strobes, only the first four are written
    b_rx = rx.size(); b_wr = nwr; b_dn = ndone;
    pulse_start;
    for (int i = 1; i <= 6; i++) strobe(8'(i * 10), 0);
    add_frame;
    smp.delete();
    wait_done("basic_done");
    tick;
    tick;
    check("basic_busy_t2", busy, 1'b1);
    tick;
    check("basic_busy_t3", busy, 1'b0);
    check("basic_wr", nwr - b_wr, 4);
    check("basic_ndone", ndone - b_dn, 1);
    check("basic_err", err, 1'b0);
    compare_rx("basic_rx", b_rx);
    // underrun after two reads
    b_rx = rx.size(); b_dn = ndone;
    lim = nrd + 2;
    pulse_start;
    for (int i = 1; i <= 4; i++) strobe(8'(i * 10), 0);
    smp.delete();
    add_hdr;
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd20);
    wait_idle("under_idle");
    check("under_err", err, 1'b1);
    check("under_ndone", ndone - b_dn, 0);
    compare_rx("under_rx", b_rx);
    lim = -1;
    do_flush;
    // random frame; start also clears the sticky error
    b_rx = rx.size();
    pulse_start;
    check("err_cleared", err, 1'b0);
    for (int i = 0; i < DN; i++) strobe(8'($urandom), int'($urandom_range(0, 2)));
    add_frame;
    wait_done("rand_done");
    wait_idle("rand_idle");
    compare_rx("rand_rx", b_rx);
    // continuous: two frames, second capture 3 cycles after first done
    b_rx = rx.size(); b_dn = ndone;
    cont = 1'b1;
    pulse_start;
    for (int i = 0; i < DN; i++) strobe(8'($urandom), int'($urandom_range(0, 2)));
    add_frame;
    wait_done("cont_done1");
    tick;
    tick;
    adc_data = 8'($urandom);
    sen = 1'b1;
    #1;
    check("cont_not_yet", wrreq, 1'b0);
    tick;
    check("cont_recapture", wrreq, 1'b1);
    smp.push_back(adc_data);
    tick;
    sen = 1'b0;
    cont = 1'b0;
    for (int i = 1; i < DN; i++) strobe(8'($urandom), int'($urandom_range(0, 2)));
    add_frame;
    wait_done("cont_done2");
    wait_idle("cont_idle");
    check("cont_ndone", ndone - b_dn, 2);
    compare_rx("cont_rx", b_rx);
    // busy stall held across SEND
    b_rx = rx.size();
    pulse_start;
    for (int i = 0; i < DN; i++) strobe(8'($urandom), int'($urandom_range(0, 2)));
    add_frame;
    k = 0;
    while (!rdreq && k < 200) begin
      tick;
      k++;
    end
    check("stall_rdreq_seen", rdreq, 1'b1);
    tick;
    stall = 1'b1;
    b_st = nstart; b_rd = nrd;
    repeat (20) tick;
    check("stall_no_start", nstart - b_st, 0);
    check("stall_no_rdreq", nrd - b_rd, 0);
    stall = 1'b0;
    wait_done("stall_done");
    wait_idle("stall_idle");
    compare_rx("stall_rx", b_rx);
    // asynchronous reset in the middle of readout
    b_rx = rx.size();
    pulse_start;
    for (int i = 0; i < DN; i++) strobe(8'($urandom), 0);
    smp.delete();
    k = 0;
    while (rx.size() < b_rx + HB + 2 && k < 300) begin
      tick;
      k++;
    end
    check("mid_two_bytes", rx.size() - b_rx, HB + 2);
    #3 rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 1'b0);
    check("mid_rdreq", rdreq, 1'b0);
    check("mid_wrreq", wrreq, 1'b0);
    check("mid_start", tx_start, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_err", err, 1'b0);
    check("mid_txd", txd, 8'h00);
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      sen = 1'b1;
      #1;
      check("post_wrreq", wrreq, 1'b0);
      check("post_busy", busy, 1'b0);
      tick;
    end
    sen = 1'b0;
    do_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
